// File: rtl/dsd_pkg.sv
// Shared definitions for the lab datapath: controller states and default operand width.
package dsd_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_adder.sv
// WIDTH-bit ripple-carry adder assembled from per-bit full-adder cells.
module nibble_adder
    import dsd_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             cin,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             cout,
    output logic [WIDTH-1:0] s
);

    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign cout = c[WIDTH];

endmodule

// File: rtl/seq_mult4.sv
// Shift-and-add unsigned multiplier: one partial-product add per cycle through a
// ripple-carry adder, 2*WIDTH-bit product delivered with a one-cycle done pulse.
module seq_mult4
    import dsd_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned PW    = 2 * WIDTH;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] mcand;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic [PW-1:0]    step;

    assign addend = mq[0] ? mcand : '0;

    nibble_adder #(.WIDTH(WIDTH)) u_add (
        .cin  (1'b0),
        .x    (acc),
        .y    (addend),
        .cout (carry),
        .s    (sum)
    );

    // Carry lands in the top bit, so the full-scale product never overflows.
    assign step = {carry, sum, mq[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            acc     <= '0;
            mq      <= '0;
            mcand   <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand <= a;
                        mq    <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= step[PW-1:WIDTH];
                    mq  <= step[WIDTH-1:0];
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        product <= step;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult4.sv
// Self-checking bench for seq_mult4: directed jobs, full operand sweep and random
// traffic, all compared every cycle against a job-timeline reference model.
module tb_seq_mult4;

    localparam int W   = 4;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [2*W-1:0] product;

    int n_tests = 0;
    int n_fail  = 0;

    seq_mult4 #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a job is a timeline; cycle k after acceptance (1..W busy, W+1 done).
    int           m_cyc  = -1;
    int           m_a    = 0;
    int           m_b    = 0;
    logic [2*W-1:0] m_prod = '0;
    logic         chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_cyc  = -1;
            m_prod = '0;
        end else if (m_cyc == -1) begin
            if (start) begin
                m_cyc = 1;
                m_a   = int'(a);
                m_b   = int'(b);
            end
        end else if (m_cyc == LAT) begin
            m_cyc = -1;
        end else begin
            m_cyc++;
            if (m_cyc == LAT) m_prod = (2*W)'(m_a * m_b);
        end
        chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",    32'(busy),    32'(m_cyc >= 1 && m_cyc <= W));
            check("done",    32'(done),    32'(m_cyc == LAT));
            check("product", 32'(product), 32'(m_prod));
        end
    end

    // Caller is at a negedge; returns the number of cycles until done is seen.
    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 20);
        if (!done) check({tag, "_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic pulse_job(input logic [W-1:0] ja, input logic [W-1:0] jb, output int lat);
        a     = ja;
        b     = jb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!done) check("job_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        int lat;
        int gap;

        // Reset held two cycles, then idle.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_prod", 32'(product), 32'h00);
        end

        pulse_job(4'hF, 4'hF, lat);
        check("ff_lat", 32'(lat), 32'd5);
        check("ff_prod", 32'(product), 32'hE1);
        repeat (4) @(negedge clk);
        check("ff_hold", 32'(product), 32'hE1);

        pulse_job(4'h9, 4'h6, lat);
        check("96_prod", 32'(product), 32'h36);
        @(negedge clk);

        pulse_job(4'h0, 4'hB, lat);
        check("0b_lat", 32'(lat), 32'd5);
        check("0b_prod", 32'(product), 32'h00);
        @(negedge clk);

        // start held through RUN with operands toggled mid-job.
        a = 4'h3; b = 4'h5; start = 1'b1;
        repeat (2) @(negedge clk);
        a = 4'h9; b = 4'h9;
        wait_done("held1", lat);
        check("held_prod1", 32'(product), 32'h0F);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!busy && gap < 10);
        check("held_gap", 32'(gap), 32'd2);
        start = 1'b0;
        wait_done("held2", lat);
        check("held_prod2", 32'(product), 32'h51);
        @(negedge clk);

        // Reset mid-job aborts it.
        a = 4'h7; b = 4'h7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_prod", 32'(product), 32'h00);
        repeat (6) @(negedge clk);
        pulse_job(4'h2, 4'h3, lat);
        check("23_prod", 32'(product), 32'h06);
        @(negedge clk);

        // Exhaustive back-to-back sweep with start held high.
        start = 1'b1;
        for (int i = 0; i < 256; i++) begin
            a = W'(i >> 4);
            b = W'(i & 15);
            wait_done("sweep", lat);
            check("sweep_prod", 32'(product), 32'(i >> 4) * 32'(i & 15));
        end
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            start = 1'($urandom_range(0, 1));
            a     = W'($urandom);
            b     = W'($urandom);
            rst   = ($urandom_range(0, 39) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        start = 1'b0;
        repeat (8) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_mult4.md
Name: seq_mult4

Overview:
- Sequential shift-and-add unsigned multiplier built around a WIDTH-bit ripple-carry adder stage.
- Sits directly downstream of that adder: it feeds the adder one partial-product operand pair per cycle and consumes its sum and carry-out.
- Accepts one operand pair on a start pulse and returns a 2*WIDTH-bit product after a fixed latency, signalled by a done pulse.
- Gives the lab datapath a multiply unit without a combinational array.

Parameters:
- WIDTH, 4, operand width in bits; product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH), width of the step counter (localparam, derived).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only when state is IDLE.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; product valid.
- product  output  2*WIDTH  registered result; held until the next completion.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, busy=0, done=0, product=0.
  - Internal acc, mq, mcand and cnt cleared.
  - Reset has priority over everything else.
- Registers:
  - acc[WIDTH-1:0]: high partial product.
  - mq[WIDTH-1:0]: multiplier, shifting toward the low product bits.
  - mcand[WIDTH-1:0]: held multiplicand.
  - cnt[CNT_W-1:0]: step counter.
- IDLE:
  - If start=1 at edge T: mcand<=a, mq<=b, acc<=0, cnt<=0, state<=RUN.
  - Otherwise stay in IDLE.
  - busy=0 and done=0 in IDLE.
- RUN (busy=1), one step per edge:
  - Adder inputs: x=acc, y=(mq[0] ? mcand : 0), cin=0, giving {c,sum}.
  - Update: {acc,mq} <= {c,sum,mq[WIDTH-1:1]}, a logical right shift of the (2*WIDTH+1)-bit concatenation.
  - cnt<=cnt+1.
  - When cnt==WIDTH-1 on this edge: the step still executes, product<={c,sum,mq[WIDTH-1:1]}, and state<=DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, with product valid in that cycle.
  - state<=IDLE unconditionally.
  - start asserted in DONE is ignored.
- Latency:
  - start sampled at edge T.
  - busy high in cycles T+1 through T+WIDTH.
  - done high in cycle T+WIDTH+1.
  - For WIDTH=4: done appears 5 cycles after the start edge.
  - Earliest next accepted start is the edge ending that done cycle +1, i.e. one cycle in IDLE between jobs.
- Boundary conditions:
  - start during RUN or DONE is ignored; a and b changes during RUN have no effect.
  - Operand zero: product=0, same latency (no early exit).
  - Max operands, 0xF*0xF: carry out of the adder propagates into acc[WIDTH-1] via the shift; no overflow is possible since the product fits in 2*WIDTH bits.
  - product changes only on the edge entering DONE (or on reset). It holds its old value through IDLE and RUN of the next job.
  - Reset mid-RUN aborts the job, produces no done pulse, and clears product to 0.
  - start held high continuously: a new job is accepted at every IDLE visit.

Decomposition:
- Shared package (dsd_pkg): state enumeration IDLE=2'd0, RUN=2'd1, DONE=2'd2; the default WIDTH constant.
- One sub-module, nibble_adder: WIDTH-bit ripple-carry adder (cin, x, y -> cout, s).
  - Built from per-bit full-adder cells.
  - Instantiated once, combinational, inside seq_mult4.
- Controller FSM, counter and shift registers stay in seq_mult4.

Test Plan:
- Reset then idle: rst=1 two cycles, release, no start -> busy=0, done=0, product=8'h00 for 10 cycles.
- a=4'hF, b=4'hF, start one cycle at edge T -> busy in T+1..T+4, done only in T+5, product=8'hE1 held until next completion.
- a=4'h9, b=4'h6 -> product=8'h36. a=4'h0, b=4'hB -> product=8'h00 with the identical 5-cycle latency.
- start held high during RUN, with a/b toggled mid-job (first job 3*5) -> product=8'h0F. The next job is accepted only after returning to IDLE. Exactly one done pulse per job.
- rst asserted at cycle T+2 of a job 7*7 -> no done pulse, product=8'h00, busy=0 next cycle. A following start with 2*3 gives product=8'h06.
- Exhaustive sweep of all 256 (a,b) pairs, back-to-back with start held high -> every product equals a*b and every done is a single cycle.
